// File: rtl/la_dsync_filter_ch.sv
// la_dsync_filter_ch: one channel of the synchronizer and glitch filter.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   in     - asynchronous channel input
//   out    - synchronized, filtered level
//   rise   - registered one-cycle pulse when out goes 0->1
//   fall   - registered one-cycle pulse when out goes 1->0
module la_dsync_filter_ch #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILTER = 4,
  parameter logic        RSTVAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW    = $clog2(FILTER + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER - 1);

  logic [STAGES-1:0] sync_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_d;
  logic              out_d;
  logic              rise_d;
  logic              fall_d;
  logic              s;

  assign s = sync_q[STAGES-1];

  // Count consecutive cycles in which the synchronized level disagrees with out;
  // any agreement restarts the count, which discards short glitches.
  always_comb begin
    cnt_d  = '0;
    out_d  = out;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != out) begin
      if (cnt_q == CntLast) begin
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RSTVAL}};
      cnt_q  <= '0;
      out    <= RSTVAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
      cnt_q  <= cnt_d;
      out    <= out_d;
      rise   <= rise_d;
      fall   <= fall_d;
    end
  end

endmodule

// File: rtl/la_dsync_filter.sv
// la_dsync_filter: multi-channel synchronizer with per-channel glitch filter
// and registered edge strobes. Each channel is fully independent.
//
// Parameters:
//   PROP    - implementation property string, passed through unchanged
//   WIDTH   - number of channels
//   STAGES  - synchronizer depth (>= 2)
//   FILTER  - stable cycles required before out changes (>= 1)
//   RSTVAL  - per-channel reset value of chain and out
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   in   [WIDTH]     - asynchronous inputs
//   out  [WIDTH]     - synchronized, filtered levels
//   rise [WIDTH]     - one-cycle pulse on out 0->1
//   fall [WIDTH]     - one-cycle pulse on out 1->0
module la_dsync_filter #(
  parameter string             PROP   = "DEFAULT",
  parameter int unsigned       WIDTH  = 1,
  parameter int unsigned       STAGES = 2,
  parameter int unsigned       FILTER = 4,
  parameter logic [WIDTH-1:0]  RSTVAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2 || FILTER < 1) begin : g_bad_params
    $fatal(1, "la_dsync_filter(%s): need STAGES >= 2 and FILTER >= 1", PROP);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    la_dsync_filter_ch #(
      .STAGES(STAGES),
      .FILTER(FILTER),
      .RSTVAL(RSTVAL[i])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_la_dsync_filter.sv
// Testbench for la_dsync_filter. Four instances with different parameters share
// one clock and reset; a behavioural model tracks every channel of each.
module tb_la_dsync_filter;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_a  = 4'b0101;
  logic       in_b  = 1'b0;
  logic       in_c  = 1'b0;
  logic [7:0] in_d  = 8'h00;

  logic [3:0] out_a, rise_a, fall_a;
  logic       out_b, rise_b, fall_b;
  logic       out_c, rise_c, fall_c;
  logic [7:0] out_d, rise_d, fall_d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c_since  = 0;
  logic c_samp [3];

  always #5 clk = ~clk;

  la_dsync_filter #(.WIDTH(4), .STAGES(2), .FILTER(4), .RSTVAL(4'b1010)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a));
  la_dsync_filter #(.WIDTH(1), .STAGES(3), .FILTER(5), .RSTVAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b));
  la_dsync_filter #(.WIDTH(1), .STAGES(2), .FILTER(1), .RSTVAL(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c));
  la_dsync_filter #(.WIDTH(8), .STAGES(2), .FILTER(4), .RSTVAL(8'h00)) dut_d (
    .clk(clk), .reset(reset), .in(in_d), .out(out_d), .rise(rise_d), .fall(fall_d));

  function automatic int ms(int m);
    return (m == 1) ? 3 : 2;
  endfunction

  function automatic int mf(int m);
    case (m)
      1:       return 5;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] rst_of(int m);
    return (m == 0) ? 8'h0A : 8'h00;
  endfunction

  function automatic logic [7:0] in_of(int m);
    case (m)
      0:       return {4'b0, in_a};
      1:       return {7'b0, in_b};
      2:       return {7'b0, in_c};
      default: return in_d;
    endcase
  endfunction

  function automatic logic [7:0] dout_of(int m);
    case (m)
      0:       return {4'b0, out_a};
      1:       return {7'b0, out_b};
      2:       return {7'b0, out_c};
      default: return out_d;
    endcase
  endfunction

  function automatic logic [7:0] drise_of(int m);
    case (m)
      0:       return {4'b0, rise_a};
      1:       return {7'b0, rise_b};
      2:       return {7'b0, rise_c};
      default: return rise_d;
    endcase
  endfunction

  function automatic logic [7:0] dfall_of(int m);
    case (m)
      0:       return {4'b0, fall_a};
      1:       return {7'b0, fall_b};
      2:       return {7'b0, fall_c};
      default: return fall_d;
    endcase
  endfunction

  // Reference model: m_hist holds the input samples of recent edges (age 0 newest).
  // The synchronized level seen at an edge is the input sampled STAGES edges earlier;
  // out flips once that level has disagreed with out on FILTER consecutive edges.
  logic [7:0] m_out  [4];
  logic [7:0] m_rise [4];
  logic [7:0] m_fall [4];
  logic       m_hist [4][8][8];
  int         m_streak [4][8];

  always @(posedge clk or posedge reset) begin
    for (int m = 0; m < 4; m++) begin
      logic [7:0] iv;
      logic [7:0] rv;
      iv = in_of(m);
      rv = rst_of(m);
      for (int c = 0; c < 8; c++) begin
        if (reset) begin
          for (int k = 0; k < 8; k++) m_hist[m][c][k] = rv[c];
          m_streak[m][c] = 0;
          m_out[m][c]    = rv[c];
          m_rise[m][c]   = 1'b0;
          m_fall[m][c]   = 1'b0;
        end else begin
          logic sv;
          sv = m_hist[m][c][ms(m)-1];
          for (int k = 7; k > 0; k--) m_hist[m][c][k] = m_hist[m][c][k-1];
          m_hist[m][c][0] = iv[c];
          m_rise[m][c] = 1'b0;
          m_fall[m][c] = 1'b0;
          if (sv != m_out[m][c]) begin
            m_streak[m][c]++;
            if (m_streak[m][c] == mf(m)) begin
              m_out[m][c]    = sv;
              m_rise[m][c]   = sv;
              m_fall[m][c]   = ~sv;
              m_streak[m][c] = 0;
            end
          end else begin
            m_streak[m][c] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("out[%0d] cyc%0d", m, cyc), dout_of(m), m_out[m]);
      chk($sformatf("rise[%0d] cyc%0d", m, cyc), drise_of(m), m_rise[m]);
      chk($sformatf("fall[%0d] cyc%0d", m, cyc), dfall_of(m), m_fall[m]);
      chk($sformatf("both[%0d] cyc%0d", m, cyc), drise_of(m) & dfall_of(m), 8'h00);
    end
  endtask

  // One clock: record in_c, pass an edge, check on the falling edge.
  task automatic step();
    c_samp[2] = c_samp[1];
    c_samp[1] = c_samp[0];
    c_samp[0] = in_c;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    c_since++;
    check_all();
    // With FILTER=1 out is the input sampled two edges earlier.
    if (c_since >= 3 && !reset) chk("c_delay", {7'b0, out_c}, {7'b0, c_samp[2]});
    if (cyc % 2 == 0) in_c = ~in_c;
  endtask

  initial begin
    int   r_cnt;
    int   f_cnt;
    logic seen;

    c_samp[0] = 1'b0;
    c_samp[1] = 1'b0;
    c_samp[2] = 1'b0;

    // Reset held with in differing from RSTVAL.
    repeat (3) begin
      step();
      chk("rst_out_a", {4'b0, out_a}, 8'h0A);
      chk("rst_strb_a", {rise_a, fall_a}, 8'h00);
    end

    reset   = 1'b0;
    c_since = 0;
    in_b    = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 1) chk("rel_strb_a", {rise_a, fall_a}, 8'h00);
      if (e == 5) chk("a_e5_out", {4'b0, out_a}, 8'h0A);
      if (e == 6) begin
        chk("a_e6_out", {4'b0, out_a}, 8'h05);
        chk("a_e6_rise", {4'b0, rise_a}, 8'h05);
        chk("a_e6_fall", {4'b0, fall_a}, 8'h0A);
      end
      if (e == 7) chk("a_e7_strb", {rise_a, fall_a}, 8'h00);
      if (e == 7) chk("b_e7_out", {7'b0, out_b}, 8'h00);
      if (e == 8) chk("b_e8_out_rise", {6'b0, out_b, rise_b}, 8'h03);
      if (e == 9) chk("b_e9_out_rise", {6'b0, out_b, rise_b}, 8'h02);
    end

    // 3-cycle glitch on channel 1 of dut_a must be rejected.
    in_a = 4'b0111;
    repeat (3) step();
    in_a  = 4'b0101;
    seen  = 1'b0;
    r_cnt = 0;
    repeat (12) begin
      step();
      if (out_a[1]) seen = 1'b1;
      r_cnt += int'(rise_a[1]) + int'(fall_a[1]);
    end
    chk("glitch3_out", {7'b0, seen}, 8'h00);
    chk("glitch3_strb", 8'(r_cnt), 8'h00);

    // 4-cycle pulse is accepted: one rise and one fall.
    r_cnt = 0;
    f_cnt = 0;
    in_a  = 4'b0111;
    for (int i = 0; i < 18; i++) begin
      if (i == 4) in_a = 4'b0101;
      step();
      r_cnt += int'(rise_a[1]);
      f_cnt += int'(fall_a[1]);
    end
    chk("pulse4_rise", 8'(r_cnt), 8'h01);
    chk("pulse4_fall", 8'(f_cnt), 8'h01);

    // Reset in the middle of a count on dut_b.
    in_b = 1'b0;
    repeat (12) step();
    in_b = 1'b1;
    repeat (5) step();
    chk("midcnt_b_out", {7'b0, out_b}, 8'h00);
    reset = 1'b1;
    #1;
    chk("async_rst_a", {4'b0, out_a}, 8'h0A);
    chk("async_rst_b", {6'b0, out_b, rise_b}, 8'h00);
    repeat (2) step();
    reset   = 1'b0;
    c_since = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 6) chk("rr_a_e6_out", {4'b0, out_a}, 8'h05);
      if (e == 7) chk("rr_b_e7_out", {7'b0, out_b}, 8'h00);
      if (e == 8) chk("rr_b_e8_out_rise", {6'b0, out_b, rise_b}, 8'h03);
    end

    // Random independent toggling on all channels.
    repeat (400) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(5) == 0) in_d[c] = ~in_d[c];
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(7) == 0) in_a[c] = ~in_a[c];
      end
      if ($urandom_range(7) == 0) in_b = ~in_b;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/la_dsync_filter.md
# la_dsync_filter

Multi-channel synchronizer with a configurable number of stages, a per-channel glitch filter and registered edge strobes. It replaces ad-hoc two-flop synchronizers plus hand-written debouncers on slow asynchronous inputs: pads, straps, and status lines from other clock domains. Each channel is synchronized independently. The output changes only after the synchronized value has held steady for a programmable number of cycles.

## Interface
- PROP, "DEFAULT": implementation property string, passed through unchanged.
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchronizer flop depth; legal values are 2 or more.
- FILTER, 4: number of consecutive stable cycles required before `out` changes; legal values are 1 or more; 1 means no filtering.
- RSTVAL, {WIDTH{1'b0}}: per-channel reset value of the synchronizer chain and of `out`.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  asynchronous channel inputs.
- out  output  WIDTH  synchronized and filtered level.
- rise  output  WIDTH  one-cycle pulse when `out` goes 0->1.
- fall  output  WIDTH  one-cycle pulse when `out` goes 1->0.

## Operation
- Synchronizer chain:
  - STAGES flops per channel, shifting toward stage STAGES-1.
  - s[i] = stage STAGES-1 of channel i.
- Filter, per channel, with counter cnt of width $clog2(FILTER+1):
  - If s == out: cnt <= 0.
  - If s != out and cnt == FILTER-1: out <= s, cnt <= 0, and the matching rise or fall is asserted.
  - If s != out otherwise: cnt <= cnt+1.
  - Any return of s to `out` before the count completes clears cnt. The glitch is discarded and produces no strobe.
- Strobes:
  - rise and fall are registered.
  - They assert in the same cycle that `out` first shows the new value, for exactly one cycle.
  - rise and fall are never both high on one channel.
- Channels share no state. Simultaneous changes on several channels are each handled independently.
- Counter wrap: not possible, because cnt is bounded by FILTER-1.

## Timing
- Reset values:
  - chain and out = RSTVAL.
  - cnt = 0.
  - rise = fall = 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). Pending counts are lost.
- Reset release: no strobe fires, because the chain equals `out`.
  - If `in` differs from RSTVAL at release, the change propagates normally and its strobe fires.
- Latency: `in` changes stably before edge 1; `out`, rise and fall update at edge STAGES+FILTER.
  - Example: STAGES=2, FILTER=4 gives a 6-cycle latency.
- Minimum accepted pulse: s must differ from `out` for FILTER consecutive sampled cycles. Shorter pulses are rejected.
- Back-to-back transitions: the next transition can begin counting on the cycle after `out` updates.
- No combinational path from `in` to any output.

## Structure
- No shared package. All derived widths are localparams computed from the parameters.
- One sub-module, la_dsync_filter_ch, instantiated WIDTH times in a generate loop.
  - It holds one channel's synchronizer chain, counter, `out` flop and strobe flops.
  - Parameters: STAGES, FILTER, RSTVAL bit.
- The top level only slices buses and fans out clk and reset.
- Elaboration-time check: STAGES < 2 or FILTER < 1 is a fatal error.

## Test plan
- Reset: WIDTH=4, RSTVAL=4'b1010, hold reset with `in`=4'b0101 → out=4'b1010, rise=fall=0 throughout reset and on release.
  - After release, out becomes 4'b0101 at edge 6, with rise=4'b0101 and fall=4'b1010 for one cycle.
- Latency: STAGES=3, FILTER=5, `in` 0->1 → out=1 and rise=1 at exactly edge 8; rise low at edge 9.
- Glitch rejection: FILTER=4, `in` pulsed high for 3 cycles → out stays 0 with no strobe.
  - A 4-cycle pulse → out rises, then falls, with one rise and one fall.
- FILTER=1: `in` toggles every 2 cycles → out tracks `in` delayed STAGES+1 cycles, with alternating strobes.
- Reset mid-count: assert reset while cnt=2 → out=RSTVAL and cnt=0 immediately.
  - After release, the full STAGES+FILTER latency applies again.
- Independent channels: WIDTH=8, random independent toggling per channel → check every channel against a scoreboard model for:
  - out;
  - strobes one cycle wide;
  - rise and fall never both high on one channel.
